// File: rtl/tick_timer_gen_pkg.sv
// ---------------------------------------------------------------------------
// tick_timer_gen_pkg
//   Shared definitions for the timer tick generator.
//   - state_t              : controller states (IDLE, RUN, DONE)
//   - DEFAULT_PERIOD_50MHZ : period loaded at reset, one second at 50 MHz
//   - MIN_PERIOD           : smallest storable period (tick every cycle)
// ---------------------------------------------------------------------------
package tick_timer_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_PERIOD_50MHZ = 50_000_000;
    localparam int unsigned MIN_PERIOD           = 1;

endpackage : tick_timer_gen_pkg

// File: rtl/tick_timer_gen.sv
// ---------------------------------------------------------------------------
// tick_timer_gen
//   Programmable tick generator. Counts clk cycles and emits a one-cycle
//   registered tick strobe every `period` cycles, periodic or one-shot, with
//   start/stop/pause control and a wrapping tick counter.
//
// Parameters
//   CNT_W          width of the period register and cycle down-counter
//   DEFAULT_PERIOD period loaded at reset
//   TCNT_W         width of tick_count
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      begin counting from IDLE or DONE (ignored in RUN)
//   stop       abort to IDLE, has priority over start
//   pause      freeze the down-counter while in RUN
//   oneshot    sampled with start: 1 = single tick then DONE
//   load       write period_in into the period register (0/1 stored as 1)
//   period_in  new period in clk cycles
//   tick       one-cycle strobe
//   busy       high while in RUN
//   done       high while in DONE
//   tick_count ticks since reset or last start, wrapping
// ---------------------------------------------------------------------------
module tick_timer_gen
    import tick_timer_gen_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_50MHZ,
    parameter int unsigned TCNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              oneshot,
    input  logic              load,
    input  logic [CNT_W-1:0]  period_in,
    output logic              tick,
    output logic              busy,
    output logic              done,
    output logic [TCNT_W-1:0] tick_count
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_DEF  = CNT_W'(DEFAULT_PERIOD);
    localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);

    state_t             state,      state_nxt;
    logic [CNT_W-1:0]   period,     period_nxt;
    logic [CNT_W-1:0]   cnt,        cnt_nxt;
    logic               mode,       mode_nxt;
    logic               tick_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [TCNT_W-1:0]  tcnt_nxt;

    // Next-state, counter and output computation.
    // Reloads read `period` (the registered value), so a load in the same
    // cycle as a reload only affects the following interval.
    always_comb begin
        state_nxt  = state;
        period_nxt = period;
        cnt_nxt    = cnt;
        mode_nxt   = mode;
        tcnt_nxt   = tick_count;
        tick_nxt   = 1'b0;

        if (load) begin
            period_nxt = (period_in <= CNT_ONE) ? CNT_ONE : period_in;
        end

        case (state)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = period - CNT_ONE;
                    mode_nxt  = oneshot;
                    tcnt_nxt  = '0;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (!pause) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_ONE;
                    end else begin
                        tick_nxt = 1'b1;
                        tcnt_nxt = tick_count + TCNT_ONE;
                        if (mode) begin
                            state_nxt = ST_DONE;
                        end else begin
                            cnt_nxt = period - CNT_ONE;
                        end
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Status flags are registered copies of the state being entered.
        busy_nxt = (state_nxt == ST_RUN);
        done_nxt = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            period     <= CNT_DEF;
            cnt        <= '0;
            mode       <= 1'b0;
            tick       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tick_count <= '0;
        end else begin
            state      <= state_nxt;
            period     <= period_nxt;
            cnt        <= cnt_nxt;
            mode       <= mode_nxt;
            tick       <= tick_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            tick_count <= tcnt_nxt;
        end
    end

    busy_done_exclusive: assert property (@(posedge clk) !(busy && done));

endmodule : tick_timer_gen
